// File: rtl/net_pkg.sv
// Shared network definitions: header field widths, framing constants and
// the arbiter state type used by the TX bus arbiter.
package net_pkg;

  localparam int ID_W      = 2;
  localparam int LEN_W     = 4;
  localparam int PAYLOAD_W = 128;

  localparam logic [15:0] PREAMBLE_PATTERN = 16'hAAAA;
  localparam logic [7:0]  SFD_PATTERN      = 8'hAB;
  // Preamble + SFD + header + max payload + CRC; sizes the framer watchdog.
  localparam int FRAME_MAX_BITS = 168;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_t;

  function automatic int id_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tx_bus_arbiter_rr_arbiter.sv
// Combinational round-robin pick: the first set request strictly after
// rr_ptr (wrapping), returned as one-hot, index and an any-request flag.
module rr_arbiter
  import net_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IDX_W  = id_bits(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   index,
  output logic               any
);

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [IDX_W-1:0]     offset;
  int                   sum;

  assign req_dbl = {req, req};
  // Rotating right by rr_ptr+1 puts the highest-priority requester at bit 0.
  assign req_rot = req_dbl[int'(rr_ptr) + 1 +: NUM_REQ];
  assign any     = |req;

  always_comb begin
    offset = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) offset = IDX_W'(i);
    end
  end

  always_comb begin
    sum = int'(rr_ptr) + 1 + int'(offset);
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    index  = IDX_W'(sum);
    onehot = any ? (NUM_REQ'(1) << index) : '0;
  end

endmodule

// File: rtl/tx_bus_arbiter.sv
// Round-robin owner of the serial TX framer: latches the winner's frame,
// strobes tx_start, waits for tx_done (or watchdog abort), then idles the line.
module tx_bus_arbiter
  import net_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int IFG_CYCLES  = 16,
  parameter int TIMEOUT_CYC = 1200
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*ID_W-1:0]       req_dest,
  input  logic [NUM_REQ*LEN_W-1:0]      req_len,
  input  logic [NUM_REQ*PAYLOAD_W-1:0]  req_payload,
  output logic [NUM_REQ-1:0]            grant,
  output logic [NUM_REQ-1:0]            done,
  output logic [NUM_REQ-1:0]            err,
  output logic                          tx_start,
  output logic [ID_W-1:0]               tx_dest,
  output logic [ID_W-1:0]               tx_src,
  output logic [LEN_W-1:0]              tx_len,
  output logic [PAYLOAD_W-1:0]          tx_payload,
  output logic                          tx_abort,
  input  logic                          tx_done,
  output logic                          busy
);

  localparam int IDX_W   = id_bits(NUM_REQ);
  localparam int TIMER_W = $clog2(TIMEOUT_CYC + 1);
  localparam int GAP_W   = (IFG_CYCLES > 0) ? $clog2(IFG_CYCLES + 1) : 1;

  arb_state_t           state_reg;
  logic [IDX_W-1:0]     rr_ptr_reg;
  logic [TIMER_W-1:0]   timer_reg;
  logic [GAP_W-1:0]     gap_cnt_reg;
  logic [NUM_REQ-1:0]   grant_reg, done_reg, err_reg;
  logic                 tx_start_reg, tx_abort_reg, busy_reg;
  logic [ID_W-1:0]      tx_dest_reg, tx_src_reg;
  logic [LEN_W-1:0]     tx_len_reg;
  logic [PAYLOAD_W-1:0] tx_payload_reg;

  logic [NUM_REQ-1:0]   arb_onehot;
  logic [IDX_W-1:0]     arb_index;
  logic                 arb_any;

  logic [ID_W-1:0]      dest_arr    [NUM_REQ];
  logic [LEN_W-1:0]     len_arr     [NUM_REQ];
  logic [PAYLOAD_W-1:0] payload_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_fields
    assign dest_arr[gi]    = req_dest[gi*ID_W +: ID_W];
    assign len_arr[gi]     = req_len[gi*LEN_W +: LEN_W];
    assign payload_arr[gi] = req_payload[gi*PAYLOAD_W +: PAYLOAD_W];
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req    (req),
    .rr_ptr (rr_ptr_reg),
    .onehot (arb_onehot),
    .index  (arb_index),
    .any    (arb_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      rr_ptr_reg     <= IDX_W'(NUM_REQ - 1);
      timer_reg      <= '0;
      gap_cnt_reg    <= '0;
      grant_reg      <= '0;
      done_reg       <= '0;
      err_reg        <= '0;
      tx_start_reg   <= 1'b0;
      tx_abort_reg   <= 1'b0;
      busy_reg       <= 1'b0;
      tx_dest_reg    <= '0;
      tx_src_reg     <= '0;
      tx_len_reg     <= '0;
      tx_payload_reg <= '0;
    end else begin
      tx_start_reg <= 1'b0;
      tx_abort_reg <= 1'b0;
      done_reg     <= '0;
      err_reg      <= '0;
      case (state_reg)
        ST_IDLE: begin
          if (arb_any) begin
            grant_reg      <= arb_onehot;
            tx_start_reg   <= 1'b1;
            tx_dest_reg    <= dest_arr[arb_index];
            tx_src_reg     <= ID_W'(arb_index);
            tx_len_reg     <= len_arr[arb_index];
            tx_payload_reg <= payload_arr[arb_index];
            rr_ptr_reg     <= arb_index;
            timer_reg      <= '0;
            busy_reg       <= 1'b1;
            state_reg      <= ST_SEND;
          end
        end
        ST_SEND: begin
          timer_reg <= timer_reg + 1'b1;
          // tx_done takes precedence over a watchdog expiry in the same cycle.
          if (tx_done || timer_reg == TIMER_W'(TIMEOUT_CYC - 1)) begin
            if (tx_done) begin
              done_reg <= grant_reg;
            end else begin
              err_reg      <= grant_reg;
              tx_abort_reg <= 1'b1;
            end
            grant_reg   <= '0;
            gap_cnt_reg <= '0;
            if (IFG_CYCLES == 0) begin
              state_reg <= ST_IDLE;
              busy_reg  <= 1'b0;
            end else begin
              state_reg <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt_reg == GAP_W'(IFG_CYCLES - 1)) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
          grant_reg <= '0;
        end
      endcase
    end
  end

  assign grant      = grant_reg;
  assign done       = done_reg;
  assign err        = err_reg;
  assign tx_start   = tx_start_reg;
  assign tx_abort   = tx_abort_reg;
  assign busy       = busy_reg;
  assign tx_dest    = tx_dest_reg;
  assign tx_src     = tx_src_reg;
  assign tx_len     = tx_len_reg;
  assign tx_payload = tx_payload_reg;

endmodule

// File: tb/tb_tx_bus_arbiter.sv
// Directed + randomized bench for tx_bus_arbiter with a framer model and a
// round-robin reference that predicts winner, fields and cycle timing.
module tb_tx_bus_arbiter;

  localparam int N   = 4;
  localparam int IFG = 16;
  localparam int TO  = 1200;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req;
  logic [7:0]   req_dest;
  logic [15:0]  req_len;
  logic [511:0] req_payload;
  logic [3:0]   grant, done, err;
  logic         tx_start, tx_abort, tx_done, busy;
  logic [1:0]   tx_dest, tx_src;
  logic [3:0]   tx_len;
  logic [127:0] tx_payload;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int last_w = N - 1;
  int exp_start = -1;
  int frame_s = 0;

  tx_bus_arbiter #(.NUM_REQ(N), .IFG_CYCLES(IFG), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_dest(req_dest), .req_len(req_len),
    .req_payload(req_payload), .grant(grant), .done(done), .err(err),
    .tx_start(tx_start), .tx_dest(tx_dest), .tx_src(tx_src), .tx_len(tx_len),
    .tx_payload(tx_payload), .tx_abort(tx_abort), .tx_done(tx_done), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: first requester set after the previous winner, wrapping.
  function automatic int pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic rand_fields(input int i);
    req_dest[2*i +: 2]      = 2'($urandom);
    req_len[4*i +: 4]       = 4'($urandom);
    req_payload[128*i +: 128] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_done_err"}, {done, err}, 0);
    chk({tag, "_strobes_busy"}, {tx_start, tx_abort, busy}, 0);
    chk({tag, "_fields"}, {tx_dest, tx_src, tx_len}, 0);
    chk({tag, "_payload"}, tx_payload, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req = '0; tx_done = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    last_w = N - 1;
    exp_start = -1;
  endtask

  // Framer model: tx_done sampled d cycles after tx_start (d outside 1..TO = never).
  task automatic do_frame(input int d, input logic [3:0] req_after, input bit drop_mid);
    int w, s, e, end_c;
    bit got, tmo;
    logic [3:0] oh;
    logic [127:0] pl;
    got = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (tx_start) begin got = 1'b1; break; end
    end
    chk("start_seen", got, 1);
    if (!got) return;
    s = cyc; frame_s = s;
    w = pick(req, last_w);
    chk("winner_valid", w >= 0, 1);
    if (w < 0) w = 0;
    if (exp_start >= 0) chk("start_cycle", s, exp_start);
    oh = 4'b0001 << w;
    pl = req_payload[128*w +: 128];
    chk("grant", grant, oh);
    chk("tx_src", tx_src, w);
    chk("tx_dest", tx_dest, req_dest[2*w +: 2]);
    chk("tx_len", tx_len, req_len[4*w +: 4]);
    chk("tx_payload", tx_payload, pl);
    chk("busy_send", busy, 1);
    last_w = w;
    tmo = !(d >= 1 && d <= TO);
    end_c = tmo ? TO : d;
    if (d == 1) tx_done = 1'b1;
    for (int j = 1; j <= end_c; j++) begin
      @(negedge clk);
      tx_done = 1'b0;
      if (j == d - 1) tx_done = 1'b1;
      if (j == 1 && drop_mid) req[w] = 1'b0;
      if (j == 1) chk("start_one_cycle", tx_start, 0);
      if (j == end_c - 1) begin
        chk("grant_held", grant, oh);
        chk("payload_stable", tx_payload, pl);
        chk("no_early_end", {done, err, tx_abort}, 0);
      end
    end
    e = cyc;
    chk("end_cycle", e, s + end_c);
    chk("done_pulse", done, tmo ? 4'b0 : oh);
    chk("err_pulse", err, tmo ? oh : 4'b0);
    chk("tx_abort", tx_abort, tmo);
    chk("grant_release", grant, 0);
    req = req_after;
    rand_fields(w);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      tx_done = 1'b0;
      if (cyc == e + 3) tx_done = 1'b1;
      if (cyc == e + 4) chk("gap_stray_done", {done, busy}, 5'b00001);
      if (cyc == e + IFG - 1) chk("gap_no_grant", {grant, tx_start}, 0);
      if (!busy) break;
    end
    chk("idle_cycle", cyc, e + IFG);
    exp_start = (req_after != 0) ? e + IFG + 1 : -1;
    $display("frame w=%0d start=%0d end=%0d d=%0d %s", w, s, e, d, tmo ? "abort" : "done");
  endtask

  initial begin
    int prev_s;
    logic [3:0] r;
    rst_n = 1'b0; req = '0; tx_done = 1'b0;
    req_dest = '0; req_len = '0; req_payload = '0;
    for (int i = 0; i < N; i++) rand_fields(i);

    do_reset();

    // tx_done while idle is ignored
    tx_done = 1'b1;
    @(negedge clk); tx_done = 1'b0;
    chk("idle_stray_done", {done, busy}, 0);

    // 1: single requester 2
    req_dest[5:4] = 2'd1; req_len[11:8] = 4'd3;
    req = 4'b0100; exp_start = cyc + 1;
    do_frame(40, 4'b0000, 1'b0);

    // 2: all requesting, fixed 200-cycle frames, order 0,1,2,3,0
    do_reset();
    req = 4'b1111; exp_start = cyc + 1;
    prev_s = -1;
    for (int f = 0; f < 5; f++) begin
      do_frame(200, (f == 4) ? 4'b0000 : 4'b1111, 1'b0);
      chk("rr_order", last_w, f % N);
      if (prev_s >= 0) chk("start_spacing", frame_s - prev_s, 200 + 1 + IFG);
      prev_s = frame_s;
    end

    // 3: watchdog abort, then the other waiting requester goes next
    req = 4'b0011; exp_start = cyc + 1;
    do_frame(0, 4'b0001, 1'b0);
    do_frame(60, 4'b0000, 1'b0);

    // 4: tx_done coincides with the timeout cycle
    req = 4'b0100; exp_start = cyc + 1;
    do_frame(TO, 4'b0000, 1'b0);

    // 5: request raised during the gap waits for it; owner drops req mid-frame
    req = 4'b0001; exp_start = cyc + 1;
    do_frame(50, 4'b0010, 1'b0);
    do_frame(30, 4'b1000, 1'b1);
    do_frame(25, 4'b0000, 1'b1);

    // randomized traffic
    req = 4'($urandom_range(1, 15)); exp_start = cyc + 1;
    for (int f = 0; f < 14; f++) begin
      int d, sel;
      sel = int'($urandom_range(0, 9));
      d = (sel == 0) ? TO + 100 : (sel == 1) ? TO : int'($urandom_range(1, 400));
      r = (req & ~(4'b0001 << pick(req, last_w))) | 4'($urandom);
      if (f == 13) r = 4'b0000;
      do_frame(d, r, 1'($urandom_range(0, 1)));
    end

    // 6: async reset in the middle of a frame
    req = 4'b0100; exp_start = -1;
    for (int n = 0; n < 50 && !tx_start; n++) @(negedge clk);
    chk("pre_reset_grant", grant, 4'b0100);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1; last_w = N - 1;
    req = 4'b1001; exp_start = cyc + 1;
    do_frame(20, 4'b1000, 1'b0);
    chk("post_reset_first", last_w, 0);
    do_frame(20, 4'b0000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
